// File: rtl/branch_rs_pkg.sv
// Shared widths, branch opcodes and entry layout for the branch reservation station.
// Also holds the CDB snoop helper used for both dispatch bypass and wakeup.
package branch_rs_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [OP_W-1:0] OP_NULL = 6'd0;
  localparam logic [OP_W-1:0] OP_JAL  = 6'd1;
  localparam logic [OP_W-1:0] OP_JALR = 6'd2;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd3;
  localparam logic [OP_W-1:0] OP_BNE  = 6'd4;
  localparam logic [OP_W-1:0] OP_BLT  = 6'd5;
  localparam logic [OP_W-1:0] OP_BGE  = 6'd6;
  localparam logic [OP_W-1:0] OP_BLTU = 6'd7;
  localparam logic [OP_W-1:0] OP_BGEU = 6'd8;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] v1;
    logic              r1;
    logic [TAG_W-1:0]  q1;
    logic [DATA_W-1:0] v2;
    logic              r2;
    logic [TAG_W-1:0]  q2;
    logic [TAG_W-1:0]  dest;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] pc;
  } rs_entry_t;

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } snoop_t;

  // Only one CDB should carry a tag per cycle; if not, ALU wins over LSB over Branch.
  function automatic snoop_t cdb_snoop(
    input logic [TAG_W-1:0]  q,
    input logic              alu_v,
    input logic [TAG_W-1:0]  alu_t,
    input logic [DATA_W-1:0] alu_d,
    input logic              lsb_v,
    input logic [TAG_W-1:0]  lsb_t,
    input logic [DATA_W-1:0] lsb_d,
    input logic              br_v,
    input logic [TAG_W-1:0]  br_t,
    input logic [DATA_W-1:0] br_d
  );
    snoop_t s;
    s = '0;
    if (alu_v && alu_t == q) begin
      s.hit  = 1'b1;
      s.data = alu_d;
    end else if (lsb_v && lsb_t == q) begin
      s.hit  = 1'b1;
      s.data = lsb_d;
    end else if (br_v && br_t == q) begin
      s.hit  = 1'b1;
      s.data = br_d;
    end
    return s;
  endfunction

endpackage

// File: rtl/branch_rs_select.sv
// Lowest-index priority encoders: first free slot for dispatch, first ready slot for issue.
module branch_rs_select #(
  parameter int unsigned ENTRY_NUM   = 8,
  parameter int unsigned ENTRY_IDX_W = 3
) (
  input  logic [ENTRY_NUM-1:0]   busy,
  input  logic [ENTRY_NUM-1:0]   ready,
  output logic [ENTRY_IDX_W-1:0] free_idx,
  output logic                   free_found,
  output logic [ENTRY_IDX_W-1:0] issue_idx,
  output logic                   issue_found
);

  always_comb begin
    free_idx    = '0;
    free_found  = 1'b0;
    issue_idx   = '0;
    issue_found = 1'b0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = ENTRY_IDX_W'(i);
      end
      if (busy[i] && ready[i] && !issue_found) begin
        issue_found = 1'b1;
        issue_idx   = ENTRY_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/branch_rs.sv
// Reservation station for branch/jump instructions: holds entries until both operands
// arrive via CDB snooping, then issues one ready entry per cycle to the branch unit.
module branch_rs
  import branch_rs_pkg::*;
#(
  parameter int unsigned ENTRY_NUM   = 8,
  parameter int unsigned ENTRY_IDX_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              clear,
  input  logic              dispatch_valid,
  input  logic [OP_W-1:0]   dispatch_op,
  input  logic [DATA_W-1:0] dispatch_reg1,
  input  logic              dispatch_reg1_ready,
  input  logic [TAG_W-1:0]  dispatch_reg1_tag,
  input  logic [DATA_W-1:0] dispatch_reg2,
  input  logic              dispatch_reg2_ready,
  input  logic [TAG_W-1:0]  dispatch_reg2_tag,
  input  logic [TAG_W-1:0]  dispatch_dest_rob,
  input  logic [DATA_W-1:0] dispatch_imm,
  input  logic [ADDR_W-1:0] dispatch_pc,
  output logic              full,
  input  logic              alu_cdb_valid,
  input  logic [TAG_W-1:0]  alu_cdb_tag,
  input  logic [DATA_W-1:0] alu_cdb_data,
  input  logic              lsb_cdb_valid,
  input  logic [TAG_W-1:0]  lsb_cdb_tag,
  input  logic [DATA_W-1:0] lsb_cdb_data,
  input  logic              br_cdb_valid,
  input  logic [TAG_W-1:0]  br_cdb_tag,
  input  logic [DATA_W-1:0] br_cdb_data,
  output logic              BranchRS_enable,
  output logic [OP_W-1:0]   BranchRS_op,
  output logic [DATA_W-1:0] BranchRS_reg1,
  output logic [DATA_W-1:0] BranchRS_reg2,
  output logic [TAG_W-1:0]  BranchRS_dest_rob,
  output logic [DATA_W-1:0] BranchRS_imm,
  output logic [ADDR_W-1:0] BranchRS_pc
);

  logic [ENTRY_NUM-1:0]   busy;
  rs_entry_t              ent [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]   ready;
  snoop_t                 wake1 [ENTRY_NUM];
  snoop_t                 wake2 [ENTRY_NUM];
  snoop_t                 byp1;
  snoop_t                 byp2;
  rs_entry_t              new_ent;
  logic [ENTRY_IDX_W-1:0] free_idx;
  logic                   free_found;
  logic [ENTRY_IDX_W-1:0] issue_idx;
  logic                   issue_found;

  assign full = &busy;

  always_comb begin
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      ready[i] = ent[i].r1 && ent[i].r2;
      wake1[i] = cdb_snoop(ent[i].q1, alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
                           lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data,
                           br_cdb_valid, br_cdb_tag, br_cdb_data);
      wake2[i] = cdb_snoop(ent[i].q2, alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
                           lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data,
                           br_cdb_valid, br_cdb_tag, br_cdb_data);
    end
  end

  // Incoming entry with same-cycle CDB bypass applied to any pending operand.
  always_comb begin
    byp1 = cdb_snoop(dispatch_reg1_tag, alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
                     lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data,
                     br_cdb_valid, br_cdb_tag, br_cdb_data);
    byp2 = cdb_snoop(dispatch_reg2_tag, alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
                     lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data,
                     br_cdb_valid, br_cdb_tag, br_cdb_data);
    new_ent      = '0;
    new_ent.op   = dispatch_op;
    new_ent.dest = dispatch_dest_rob;
    new_ent.imm  = dispatch_imm;
    new_ent.pc   = dispatch_pc;
    new_ent.q1   = dispatch_reg1_tag;
    new_ent.q2   = dispatch_reg2_tag;
    if (dispatch_reg1_ready) begin
      new_ent.r1 = 1'b1;
      new_ent.v1 = dispatch_reg1;
    end else if (byp1.hit) begin
      new_ent.r1 = 1'b1;
      new_ent.v1 = byp1.data;
    end
    if (dispatch_reg2_ready) begin
      new_ent.r2 = 1'b1;
      new_ent.v2 = dispatch_reg2;
    end else if (byp2.hit) begin
      new_ent.r2 = 1'b1;
      new_ent.v2 = byp2.data;
    end
  end

  branch_rs_select #(
    .ENTRY_NUM   (ENTRY_NUM),
    .ENTRY_IDX_W (ENTRY_IDX_W)
  ) u_select (
    .busy        (busy),
    .ready       (ready),
    .free_idx    (free_idx),
    .free_found  (free_found),
    .issue_idx   (issue_idx),
    .issue_found (issue_found)
  );

  // Free slot is chosen from registered busy, so it never aliases the issuing slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy              <= '0;
      for (int unsigned i = 0; i < ENTRY_NUM; i++) ent[i] <= '0;
      BranchRS_enable   <= 1'b0;
      BranchRS_op       <= '0;
      BranchRS_reg1     <= '0;
      BranchRS_reg2     <= '0;
      BranchRS_dest_rob <= '0;
      BranchRS_imm      <= '0;
      BranchRS_pc       <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy            <= '0;
        BranchRS_enable <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
          if (busy[i] && !ent[i].r1 && wake1[i].hit) begin
            ent[i].r1 <= 1'b1;
            ent[i].v1 <= wake1[i].data;
          end
          if (busy[i] && !ent[i].r2 && wake2[i].hit) begin
            ent[i].r2 <= 1'b1;
            ent[i].v2 <= wake2[i].data;
          end
        end
        if (issue_found) begin
          BranchRS_enable   <= 1'b1;
          BranchRS_op       <= ent[issue_idx].op;
          BranchRS_reg1     <= ent[issue_idx].v1;
          BranchRS_reg2     <= ent[issue_idx].v2;
          BranchRS_dest_rob <= ent[issue_idx].dest;
          BranchRS_imm      <= ent[issue_idx].imm;
          BranchRS_pc       <= ent[issue_idx].pc;
          busy[issue_idx]   <= 1'b0;
        end else begin
          BranchRS_enable <= 1'b0;
        end
        if (dispatch_valid && free_found) begin
          busy[free_idx] <= 1'b1;
          ent[free_idx]  <= new_ent;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: latency, wakeup, bypass, full/ordering, flush, rdy and reset.
module tb_branch_rs;
  import branch_rs_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, rdy, clear;
  logic              dispatch_valid;
  logic [OP_W-1:0]   dispatch_op;
  logic [DATA_W-1:0] dispatch_reg1, dispatch_reg2, dispatch_imm;
  logic              dispatch_reg1_ready, dispatch_reg2_ready;
  logic [TAG_W-1:0]  dispatch_reg1_tag, dispatch_reg2_tag, dispatch_dest_rob;
  logic [ADDR_W-1:0] dispatch_pc;
  logic              full;
  logic              alu_cdb_valid, lsb_cdb_valid, br_cdb_valid;
  logic [TAG_W-1:0]  alu_cdb_tag, lsb_cdb_tag, br_cdb_tag;
  logic [DATA_W-1:0] alu_cdb_data, lsb_cdb_data, br_cdb_data;
  logic              BranchRS_enable;
  logic [OP_W-1:0]   BranchRS_op;
  logic [DATA_W-1:0] BranchRS_reg1, BranchRS_reg2, BranchRS_imm;
  logic [TAG_W-1:0]  BranchRS_dest_rob;
  logic [ADDR_W-1:0] BranchRS_pc;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  branch_rs #(.ENTRY_NUM(8), .ENTRY_IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
    .dispatch_reg1(dispatch_reg1), .dispatch_reg1_ready(dispatch_reg1_ready),
    .dispatch_reg1_tag(dispatch_reg1_tag), .dispatch_reg2(dispatch_reg2),
    .dispatch_reg2_ready(dispatch_reg2_ready), .dispatch_reg2_tag(dispatch_reg2_tag),
    .dispatch_dest_rob(dispatch_dest_rob), .dispatch_imm(dispatch_imm),
    .dispatch_pc(dispatch_pc), .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_tag(alu_cdb_tag), .alu_cdb_data(alu_cdb_data),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
    .br_cdb_valid(br_cdb_valid), .br_cdb_tag(br_cdb_tag), .br_cdb_data(br_cdb_data),
    .BranchRS_enable(BranchRS_enable), .BranchRS_op(BranchRS_op),
    .BranchRS_reg1(BranchRS_reg1), .BranchRS_reg2(BranchRS_reg2),
    .BranchRS_dest_rob(BranchRS_dest_rob), .BranchRS_imm(BranchRS_imm),
    .BranchRS_pc(BranchRS_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs set before tick are sampled at its edge; outputs are read 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [OP_W-1:0] op,
                          input logic [31:0] v1, input logic r1, input logic [TAG_W-1:0] q1,
                          input logic [31:0] v2, input logic r2, input logic [TAG_W-1:0] q2,
                          input logic [TAG_W-1:0] dest, input logic [31:0] imm,
                          input logic [31:0] pc);
    dispatch_valid      = 1'b1;
    dispatch_op         = op;
    dispatch_reg1       = v1;
    dispatch_reg1_ready = r1;
    dispatch_reg1_tag   = q1;
    dispatch_reg2       = v2;
    dispatch_reg2_ready = r2;
    dispatch_reg2_tag   = q2;
    dispatch_dest_rob   = dest;
    dispatch_imm        = imm;
    dispatch_pc         = pc;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; clear = 1'b0;
    dispatch_valid = 1'b0; dispatch_op = '0;
    dispatch_reg1 = '0; dispatch_reg1_ready = 1'b0; dispatch_reg1_tag = '0;
    dispatch_reg2 = '0; dispatch_reg2_ready = 1'b0; dispatch_reg2_tag = '0;
    dispatch_dest_rob = '0; dispatch_imm = '0; dispatch_pc = '0;
    alu_cdb_valid = 1'b0; alu_cdb_tag = '0; alu_cdb_data = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_tag = '0; lsb_cdb_data = '0;
    br_cdb_valid = 1'b0; br_cdb_tag = '0; br_cdb_data = '0;

    // Reset state
    tick(); tick();
    check("rst_enable", 32'(BranchRS_enable), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_op", 32'(BranchRS_op), 32'd0);
    check("rst_pc", BranchRS_pc, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: ready BEQ, minimum latency
    dispatch(OP_BEQ, 32'd5, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 4'd2, 32'd8, 32'h100);
    tick();
    dispatch_valid = 1'b0;
    check("t1_no_early", 32'(BranchRS_enable), 32'd0);
    tick();
    check("t1_enable", 32'(BranchRS_enable), 32'd1);
    check("t1_op", 32'(BranchRS_op), 32'(OP_BEQ));
    check("t1_reg1", BranchRS_reg1, 32'd5);
    check("t1_reg2", BranchRS_reg2, 32'd5);
    check("t1_imm", BranchRS_imm, 32'd8);
    check("t1_pc", BranchRS_pc, 32'h100);
    check("t1_dest", 32'(BranchRS_dest_rob), 32'd2);
    tick();
    check("t1_enable_drop", 32'(BranchRS_enable), 32'd0);
    check("t1_hold_pc", BranchRS_pc, 32'h100);

    // 2: BNE waiting on ALU tag 3
    dispatch(OP_BNE, 32'd0, 1'b0, 4'd3, 32'd7, 1'b1, 4'd0, 4'd4, 32'd12, 32'h104);
    tick();
    dispatch_valid = 1'b0;
    tick();
    check("t2_wait", 32'(BranchRS_enable), 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd3; alu_cdb_data = 32'd9;
    tick();
    alu_cdb_valid = 1'b0;
    check("t2_wake_edge", 32'(BranchRS_enable), 32'd0);
    tick();
    check("t2_enable", 32'(BranchRS_enable), 32'd1);
    check("t2_reg1", BranchRS_reg1, 32'd9);
    check("t2_reg2", BranchRS_reg2, 32'd7);
    check("t2_dest", 32'(BranchRS_dest_rob), 32'd4);
    check("t2_op", 32'(BranchRS_op), 32'(OP_BNE));
    tick();
    check("t2_enable_drop", 32'(BranchRS_enable), 32'd0);

    // 3: BLT with same-cycle LSB bypass on reg2
    dispatch(OP_BLT, 32'd1, 1'b1, 4'd0, 32'd0, 1'b0, 4'd5, 4'd6, 32'hFFFF_FFF0, 32'h108);
    lsb_cdb_valid = 1'b1; lsb_cdb_tag = 4'd5; lsb_cdb_data = 32'hFFFF_FFFF;
    tick();
    dispatch_valid = 1'b0; lsb_cdb_valid = 1'b0;
    tick();
    check("t3_enable", 32'(BranchRS_enable), 32'd1);
    check("t3_reg2", BranchRS_reg2, 32'hFFFF_FFFF);
    check("t3_reg1", BranchRS_reg1, 32'd1);
    check("t3_imm", BranchRS_imm, 32'hFFFF_FFF0);
    tick();
    check("t3_enable_drop", 32'(BranchRS_enable), 32'd0);

    // 4: fill all eight, ignored ninth, in-order drain
    for (int i = 0; i < 8; i++) begin
      check("t4_not_full", 32'(full), 32'd0);
      dispatch(OP_BNE, 32'd0, 1'b0, 4'd1, 32'd2, 1'b1, 4'd0, 4'(i), 32'(i), 32'h200 + 32'(4 * i));
      tick();
    end
    check("t4_full", 32'(full), 32'd1);
    dispatch(OP_BEQ, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd15, 32'd0, 32'h300);
    tick();
    dispatch_valid = 1'b0;
    check("t4_full_hold", 32'(full), 32'd1);
    check("t4_no_issue", 32'(BranchRS_enable), 32'd0);
    br_cdb_valid = 1'b1; br_cdb_tag = 4'd1; br_cdb_data = 32'h40;
    tick();
    br_cdb_valid = 1'b0;
    check("t4_wake_edge", 32'(BranchRS_enable), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4_enable", 32'(BranchRS_enable), 32'd1);
      check("t4_dest", 32'(BranchRS_dest_rob), 32'(i));
      check("t4_pc", BranchRS_pc, 32'h200 + 32'(4 * i));
      check("t4_reg1", BranchRS_reg1, 32'h40);
      if (i == 0) check("t4_full_drop", 32'(full), 32'd0);
    end
    tick();
    check("t4_ninth_dropped", 32'(BranchRS_enable), 32'd0);

    // 5: flush with three busy (one ready) and a same-cycle dispatch
    dispatch(OP_BGE, 32'd0, 1'b0, 4'd6, 32'd1, 1'b1, 4'd0, 4'd1, 32'd0, 32'h400);
    tick();
    dispatch(OP_BGE, 32'd0, 1'b0, 4'd6, 32'd1, 1'b1, 4'd0, 4'd2, 32'd0, 32'h404);
    tick();
    dispatch(OP_BLTU, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd3, 32'd0, 32'h408);
    tick();
    dispatch(OP_BGEU, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd5, 32'd0, 32'h40C);
    clear = 1'b1;
    tick();
    clear = 1'b0; dispatch_valid = 1'b0;
    check("t5_enable", 32'(BranchRS_enable), 32'd0);
    check("t5_full", 32'(full), 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd6; alu_cdb_data = 32'd1;
    tick();
    alu_cdb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_issue", 32'(BranchRS_enable), 32'd0);
    end
    check("t5_pc_hold", BranchRS_pc, 32'h21C);

    // 6a: rdy low around a pending issue
    dispatch(OP_JAL, 32'd0, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd10, 32'd16, 32'h500);
    tick();
    dispatch_valid = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_frozen_en", 32'(BranchRS_enable), 32'd0);
      check("t6_frozen_dest", 32'(BranchRS_dest_rob), 32'd7);
    end
    rdy = 1'b1;
    tick();
    check("t6_enable", 32'(BranchRS_enable), 32'd1);
    check("t6_dest", 32'(BranchRS_dest_rob), 32'd10);
    check("t6_op", 32'(BranchRS_op), 32'(OP_JAL));
    tick();
    check("t6_once", 32'(BranchRS_enable), 32'd0);

    // 6b: enable frozen high while rdy low, still a single issue
    dispatch(OP_JALR, 32'h80, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd11, 32'd4, 32'h504);
    tick();
    dispatch_valid = 1'b0;
    tick();
    check("t6b_enable", 32'(BranchRS_enable), 32'd1);
    rdy = 1'b0;
    tick();
    check("t6b_frozen_high", 32'(BranchRS_enable), 32'd1);
    rdy = 1'b1;
    tick();
    check("t6b_once", 32'(BranchRS_enable), 32'd0);

    // 6c: reset mid-stream overrides rdy and discards entries
    dispatch(OP_BEQ, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 4'd9, 32'd4, 32'h600);
    tick();
    dispatch(OP_BNE, 32'd0, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0, 4'd12, 32'd4, 32'h604);
    tick();
    dispatch_valid = 1'b0;
    check("t6c_pre_enable", 32'(BranchRS_enable), 32'd1);
    rst_n = 1'b0; rdy = 1'b0;
    tick();
    rst_n = 1'b1; rdy = 1'b1;
    check("t6c_enable", 32'(BranchRS_enable), 32'd0);
    check("t6c_op", 32'(BranchRS_op), 32'd0);
    check("t6c_reg1", BranchRS_reg1, 32'd0);
    check("t6c_dest", 32'(BranchRS_dest_rob), 32'd0);
    check("t6c_pc", BranchRS_pc, 32'd0);
    check("t6c_full", 32'(full), 32'd0);
    alu_cdb_valid = 1'b1; alu_cdb_tag = 4'd2; alu_cdb_data = 32'd3;
    tick();
    alu_cdb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6c_no_stale", 32'(BranchRS_enable), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
